mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/slc3_mem_pkg.sv | 14 +
 rtl/mem_responder_mmio_port.sv | 34 +++
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_RELEASE
  } state_t;

  localparam logic [15:0]  MMIO_ADDR           = 16'hFFFF;
  localparam int unsigned  WAIT_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/mem_responder_mmio_port.sv
// Memory-mapped I/O port: address decode, switch read mux and HEX display register.
module mmio_port
  import slc3_mem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_sw,
  output logic        o_hit,
  output logic [15:0] o_rdata,
  output logic [15:0] o_hex_out
);

  logic        w_hit;
  logic [15:0] r_hex;

  assign w_hit     = (i_addr == MMIO_ADDR);
  assign o_hit     = w_hit;
  assign o_rdata   = w_hit ? i_sw : 16'h0000;
  assign o_hex_out = r_hex;

  // i_req is the accept cycle, so i_wdata here is exactly the value being latched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hex <= 16'h0000;
    end else if (i_req && w_hit && i_we) begin
      r_hex <= i_wdata;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// CPU-side memory responder: runs SRAM accesses with a fixed wait count and
// forwards the single MMIO address to mmio_port, handshaking with a one-cycle R.
module mem_responder
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_en,
  input  logic        i_we,
  input  logic [15:0] i_mar,
  input  logic [15:0] i_mdr,
  output logic [15:0] o_mdr_in,
  output logic        o_r,
  input  logic [15:0] i_sw,
  output logic [15:0] o_hex_out,
  output logic [19:0] o_addr,
  output logic [15:0] o_data_to_sram,
  input  logic [15:0] i_data_from_sram,
  output logic        o_ce_n,
  output logic        o_oe_n,
  output logic        o_we_n,
  output logic        o_ub_n,
  output logic        o_lb_n
);

  localparam int unsigned      CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic             r_r;
  logic [15:0]      r_mdr_in;
  logic [19:0]      r_addr;
  logic [15:0]      r_data_to_sram;
  logic             r_ce_n;
  logic             r_oe_n;
  logic             r_we_n;
  logic             r_ub_n;
  logic             r_lb_n;

  logic             w_accept;
  logic             w_mmio_hit;
  logic [15:0]      w_mmio_rdata;

  assign w_accept = (r_state == ST_IDLE) && i_mem_en;

  mmio_port u_mmio_port (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (w_accept),
    .i_we      (i_we),
    .i_addr    (i_mar),
    .i_wdata   (i_mdr),
    .i_sw      (i_sw),
    .o_hit     (w_mmio_hit),
    .o_rdata   (w_mmio_rdata),
    .o_hex_out (o_hex_out)
  );

  // The latched request lives in r_we, r_addr and r_data_to_sram; all are
  // loaded only on accept, so later MAR/WE/MDR wiggles cannot leak in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_we           <= 1'b0;
      r_r            <= 1'b0;
      r_mdr_in       <= 16'h0000;
      r_addr         <= 20'h00000;
      r_data_to_sram <= 16'h0000;
      r_ce_n         <= 1'b1;
      r_oe_n         <= 1'b1;
      r_we_n         <= 1'b1;
      r_ub_n         <= 1'b1;
      r_lb_n         <= 1'b1;
    end else begin
      // NOTE: default first so R is high only in the cycle after the edge that sets it.
      r_r <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_mem_en) begin
            r_we  <= i_we;
            r_cnt <= '0;
            if (w_mmio_hit) begin
              if (!i_we) r_mdr_in <= w_mmio_rdata;
              r_r     <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_addr <= {4'h0, i_mar};
              if (i_we) r_data_to_sram <= i_mdr;
              r_ce_n  <= 1'b0;
              r_ub_n  <= 1'b0;
              r_lb_n  <= 1'b0;
              r_oe_n  <= i_we;
              r_we_n  <= ~i_we;
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (r_cnt == CNT_LAST) begin
            if (!r_we) r_mdr_in <= i_data_from_sram;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_r     <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!i_mem_en) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_r            = r_r;
  assign o_mdr_in       = r_mdr_in;
  assign o_addr         = r_addr;
  assign o_data_to_sram = r_data_to_sram;
  assign o_ce_n         = r_ce_n;
  assign o_oe_n         = r_oe_n;
  assign o_we_n         = r_we_n;
  assign o_ub_n         = r_ub_n;
  assign o_lb_n         = r_lb_n;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, random transactions
// against a behavioural memory model, reset corners and a WAIT_CYCLES=1 instance.
module tb_mem_responder;
  import slc3_mem_pkg::*;

  localparam int W0 = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Main instance (default WAIT_CYCLES)
  logic        mem_en, we, r;
  logic [15:0] mar, mdr, sw, mdr_in, hex_out, data_to_sram, data_from_sram;
  logic [19:0] addr;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;

  mem_responder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_en(mem_en), .i_we(we), .i_mar(mar), .i_mdr(mdr),
    .o_mdr_in(mdr_in), .o_r(r), .i_sw(sw), .o_hex_out(hex_out), .o_addr(addr),
    .o_data_to_sram(data_to_sram), .i_data_from_sram(data_from_sram),
    .o_ce_n(ce_n), .o_oe_n(oe_n), .o_we_n(we_n), .o_ub_n(ub_n), .o_lb_n(lb_n)
  );

  // WAIT_CYCLES=1 instance
  logic        m1_en, m1_we, m1_r;
  logic [15:0] m1_mar, m1_mdr, m1_sw, m1_mdr_in, m1_hex, m1_dts, m1_dfs;
  logic [19:0] m1_addr;
  logic        m1_ce_n, m1_oe_n, m1_we_n, m1_ub_n, m1_lb_n;

  mem_responder #(.WAIT_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_en(m1_en), .i_we(m1_we), .i_mar(m1_mar), .i_mdr(m1_mdr),
    .o_mdr_in(m1_mdr_in), .o_r(m1_r), .i_sw(m1_sw), .o_hex_out(m1_hex), .o_addr(m1_addr),
    .o_data_to_sram(m1_dts), .i_data_from_sram(m1_dfs),
    .o_ce_n(m1_ce_n), .o_oe_n(m1_oe_n), .o_we_n(m1_we_n), .o_ub_n(m1_ub_n), .o_lb_n(m1_lb_n)
  );

  assign m1_dfs = (!m1_ce_n && !m1_oe_n) ? (m1_addr[15:0] ^ 16'hA5A5) : 16'h0000;

  // SRAM device: 1K words, unwritten words hold a fixed pattern
  function automatic logic [15:0] init_word(input int i);
    if (i == 'h012) return 16'hBEEF;
    if (i == 'h3FE) return 16'hCAFE;
    return 16'(i) ^ 16'h5555;
  endfunction

  logic [15:0] sram_mem [1024];
  bit          sram_wr  [1024];

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      sram_mem[addr[9:0]] <= data_to_sram;
      sram_wr[addr[9:0]]  <= 1'b1;
    end
  end

  assign data_from_sram = (!ce_n && !oe_n)
                        ? (sram_wr[addr[9:0]] ? sram_mem[addr[9:0]] : init_word(int'(addr[9:0])))
                        : 16'h0000;

  // Reference model: expected memory contents and CPU-visible registers
  logic [15:0] ref_mem [1024];
  logic [15:0] exp_mdr_in, exp_hex;

  task automatic model_apply(input logic w, input logic [15:0] a, d, s);
    if (a == 16'hFFFF) begin
      if (w) exp_hex = d;
      else   exp_mdr_in = s;
    end else begin
      if (w) ref_mem[a[9:0]] = d;
      else   exp_mdr_in = ref_mem[a[9:0]];
    end
  endtask

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One CPU transaction, started at a negedge; returns at a negedge with FSM in IDLE.
  task automatic run_txn(input logic t_we, input logic [15:0] t_mar, t_mdr, t_sw,
                         input int hold, input bit drop_early,
                         input logic [15:0] e_mdr_in, e_hex, input int e_lat);
    int n = 0, ce_cnt = 0, oe_cnt = 0, wen_cnt = 0, extra_r = 0, extra_ce = 0;
    bit addr_ok = 1'b1, data_ok = 1'b1;
    bit is_mmio = (t_mar == 16'hFFFF);
    we = t_we; mar = t_mar; mdr = t_mdr; sw = t_sw; mem_en = 1'b1;
    while (r !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      if (drop_early) mem_en = 1'b0;
      mar = 16'($urandom); mdr = 16'($urandom); we = 1'($urandom);
      @(negedge clk);
      n++;
      if (ce_n === 1'b0) begin
        ce_cnt++;
        if (addr !== {4'h0, t_mar} || ub_n !== 1'b0 || lb_n !== 1'b0) addr_ok = 1'b0;
      end
      if (oe_n === 1'b0) oe_cnt++;
      if (we_n === 1'b0) begin
        wen_cnt++;
        if (data_to_sram !== t_mdr) data_ok = 1'b0;
      end
    end
    check("latency", n, e_lat);
    check("ce_cycles", ce_cnt, is_mmio ? 0 : W0);
    check("oe_cycles", oe_cnt, (!is_mmio && !t_we) ? W0 : 0);
    check("we_cycles", wen_cnt, (!is_mmio && t_we) ? W0 : 0);
    check("addr_data_ok", {addr_ok, data_ok}, 2'b11);
    check("mdr_in", mdr_in, e_mdr_in);
    check("hex_out", hex_out, e_hex);
    @(negedge clk);
    check("r_one_cycle", r, 1'b0);
    if (drop_early) begin
      check("state_release_dropped", dut.r_state, ST_RELEASE);
      @(negedge clk);
      check("state_idle_after_drop", dut.r_state, ST_IDLE);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (r !== 1'b0) extra_r++;
        if (ce_n !== 1'b1) extra_ce++;
      end
      check("held_no_second", {extra_r[15:0], extra_ce[15:0]}, 32'h0);
      check("state_release_held", dut.r_state, ST_RELEASE);
      mem_en = 1'b0;
      @(negedge clk);
      check("state_idle", dut.r_state, ST_IDLE);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] mar, mdr, sw;
    int          hold;
    bit          drop;
    logic [15:0] e_mdr_in, e_hex;
    int          e_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic        t_we;
    logic [15:0] t_mar, t_mdr, t_sw;
    int          n1, oe1;
    logic [15:0] a1;

    vecs[0] = '{1'b0, 16'h0012, 16'h0000, 16'h0000, 0,  1'b0, 16'hBEEF, 16'h0000, 3};
    vecs[1] = '{1'b1, 16'h0040, 16'h1234, 16'h0000, 0,  1'b0, 16'hBEEF, 16'h0000, 3};
    vecs[2] = '{1'b1, 16'hFFFF, 16'h00A5, 16'h0000, 0,  1'b0, 16'hBEEF, 16'h00A5, 1};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 0,  1'b0, 16'h0F0F, 16'h00A5, 1};
    vecs[4] = '{1'b0, 16'h0040, 16'h0000, 16'h0000, 10, 1'b0, 16'h1234, 16'h00A5, 3};
    vecs[5] = '{1'b0, 16'hFFFE, 16'h0000, 16'h0000, 0,  1'b0, 16'hCAFE, 16'h00A5, 3};
    vecs[6] = '{1'b0, 16'h0012, 16'h0000, 16'h0000, 0,  1'b1, 16'hBEEF, 16'h00A5, 3};
    vecs[7] = '{1'b1, 16'hFFFE, 16'h7777, 16'h0000, 0,  1'b1, 16'hBEEF, 16'h00A5, 3};

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    exp_mdr_in = 16'h0000;
    exp_hex    = 16'h0000;
    mem_en = 1'b0; we = 1'b0; mar = '0; mdr = '0; sw = '0;
    m1_en = 1'b0; m1_we = 1'b0; m1_mar = '0; m1_mdr = '0; m1_sw = '0;

    #1 rst_n = 1'b0;
    #10;
    check("rst_r", r, 1'b0);
    check("rst_mdr_in", mdr_in, 16'h0000);
    check("rst_hex", hex_out, 16'h0000);
    check("rst_addr", addr, 20'h00000);
    check("rst_dts", data_to_sram, 16'h0000);
    check("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    check("rst_state", dut.r_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      model_apply(vecs[i].we, vecs[i].mar, vecs[i].mdr, vecs[i].sw);
      run_txn(vecs[i].we, vecs[i].mar, vecs[i].mdr, vecs[i].sw, vecs[i].hold, vecs[i].drop,
              vecs[i].e_mdr_in, vecs[i].e_hex, vecs[i].e_lat);
    end

    for (int k = 0; k < 30; k++) begin
      t_we  = 1'($urandom);
      t_mar = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 'h3FE));
      t_mdr = 16'($urandom);
      t_sw  = 16'($urandom);
      model_apply(t_we, t_mar, t_mdr, t_sw);
      run_txn(t_we, t_mar, t_mdr, t_sw, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
              exp_mdr_in, exp_hex, (t_mar == 16'hFFFF) ? 1 : W0 + 1);
    end

    // Reset in the second ACCESS cycle of a write (0x3FF is kept out of random traffic)
    we = 1'b1; mar = 16'h03FF; mdr = 16'h9999; mem_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("abort_we_n_active", we_n, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    check("abort_r", r, 1'b0);
    check("abort_state", dut.r_state, ST_IDLE);
    check("abort_hex", hex_out, 16'h0000);
    check("abort_mdr_in", mdr_in, 16'h0000);
    we = 1'b0; mar = 16'hFFFF; sw = 16'h3C3C;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_r", r, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_mdr_in = 16'h0000;
    exp_hex    = 16'h0000;
    model_apply(1'b0, 16'hFFFF, 16'h0000, 16'h3C3C);
    run_txn(1'b0, 16'hFFFF, 16'h0000, 16'h3C3C, 0, 1'b0, exp_mdr_in, exp_hex, 1);

    for (int k = 0; k < 10; k++) begin
      t_we  = 1'($urandom);
      t_mar = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 'h3FE));
      t_mdr = 16'($urandom);
      t_sw  = 16'($urandom);
      model_apply(t_we, t_mar, t_mdr, t_sw);
      run_txn(t_we, t_mar, t_mdr, t_sw, $urandom_range(0, 2), 1'b0,
              exp_mdr_in, exp_hex, (t_mar == 16'hFFFF) ? 1 : W0 + 1);
    end

    // WAIT_CYCLES=1: back-to-back reads, one idle cycle between them
    for (int k = 0; k < 4; k++) begin
      n1  = 0;
      oe1 = 0;
      a1  = 16'($urandom_range(0, 'hFFFE));
      m1_mar = a1;
      m1_en  = 1'b1;
      while (m1_r !== 1'b1 && n1 < 20) begin
        @(negedge clk);
        n1++;
        if (m1_oe_n === 1'b0) oe1++;
      end
      check("w1_latency", n1, 2);
      check("w1_oe_cycles", oe1, 1);
      check("w1_data", m1_mdr_in, a1 ^ 16'hA5A5);
      m1_en = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("w1_idle_outputs", {m1_we_n, m1_ub_n, m1_lb_n, m1_ce_n, m1_hex, m1_dts}, {4'b1111, 32'h0});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
